hub_repeater: RTL and testbench

Parametrised successor to the basic MII repeater hub core. It repeats a single active receiver's nibble stream to every other port, and extends the basic hub with four behaviours: a minimum-length jam on collision, jabber cut-off, per-port partitioning after repeated collisions, and automatic reconnection. It sits between the per-port PHY/MII blocks and runs entirely in the MII receive clock domain. All outputs are registered.

---
 rtl/hub_repeater.sv | 214 +++++++++++++++++++++
 tb/tb_hub_repeater.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub_repeater.sv
// MII repeater hub: repeats one receiver to all other ports, jams on collision,
// cuts off jabbering streams, and partitions/reconnects misbehaving ports.
module hub_repeater #(
  parameter int unsigned PORT_COUNT      = 4,
  parameter int unsigned JAM_MIN         = 24,
  parameter int unsigned JABBER_LIMIT    = 5000,
  parameter int unsigned PARTITION_LIMIT = 31,
  parameter int unsigned RECONNECT_LIMIT = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORT_COUNT-1:0]   rx_dv,
  input  logic [PORT_COUNT-1:0]   rx_er,
  input  logic [4*PORT_COUNT-1:0] rxd,
  output logic [PORT_COUNT-1:0]   tx_en,
  output logic [PORT_COUNT-1:0]   tx_er,
  output logic [4*PORT_COUNT-1:0] txd,
  output logic                    collision,
  output logic                    jabber,
  output logic [PORT_COUNT-1:0]   partitioned
);

  localparam int unsigned CNT_W  = $clog2(JABBER_LIMIT + 1);
  localparam int unsigned CCNT_W = $clog2(PARTITION_LIMIT + 1);
  localparam int unsigned RCNT_W = $clog2(RECONNECT_LIMIT + 1);
  localparam int unsigned IDX_W  = (PORT_COUNT > 2) ? $clog2(PORT_COUNT) : 1;
  localparam int unsigned N_W    = $clog2(PORT_COUNT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REPEAT = 2'd1;
  localparam logic [1:0] ST_JAM    = 2'd2;
  localparam logic [1:0] ST_JABBER = 2'd3;

  logic [1:0]                         state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [IDX_W-1:0]                   active_q, active_d;
  logic [PORT_COUNT-1:0][CCNT_W-1:0]  ccnt_q, ccnt_d;
  logic [PORT_COUNT-1:0][RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [PORT_COUNT-1:0]              partitioned_q, partitioned_d;
  logic [PORT_COUNT-1:0]              tx_en_q, tx_en_d;
  logic [PORT_COUNT-1:0]              tx_er_q, tx_er_d;
  logic [4*PORT_COUNT-1:0]            txd_q, txd_d;
  logic                               collision_q, collision_d;
  logic                               jabber_q, jabber_d;

  logic [PORT_COUNT-1:0] eff_dv;
  logic [N_W-1:0]        n_act;
  logic [IDX_W-1:0]      first_idx;
  logic                  found;
  logic                  act_dv;
  logic                  clean_eof;
  logic                  jam_entry;
  logic [3:0]            fwd_rxd;
  logic                  fwd_er;

  // Receivers that may start or collide, and their count.
  always_comb begin
    eff_dv    = rx_dv & ~partitioned_q;
    n_act     = '0;
    first_idx = '0;
    found     = 1'b0;
    act_dv    = 1'b0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      n_act = n_act + N_W'(eff_dv[i]);
      if (eff_dv[i] && !found) begin
        first_idx = IDX_W'(i);
        found     = 1'b1;
      end
      if (IDX_W'(i) == active_q) act_dv = rx_dv[i];
    end
  end

  // Next-state decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    clean_eof = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (n_act == N_W'(1)) begin
          state_d  = ST_REPEAT;
          active_d = first_idx;
          cnt_d    = CNT_W'(1);
        end else if (n_act >= N_W'(2)) begin
          state_d = ST_JAM;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (n_act >= N_W'(2)) begin
          state_d = ST_JAM;
          cnt_d   = CNT_W'(1);
        end else if (!act_dv) begin
          state_d   = ST_IDLE;
          clean_eof = 1'b1;
        end else if (cnt_q == CNT_W'(JABBER_LIMIT)) begin
          state_d = ST_JABBER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_JAM: begin
        if (cnt_q >= CNT_W'(JAM_MIN) && n_act == '0) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(JABBER_LIMIT)) begin
          state_d = ST_JABBER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_JABBER: begin
        if (eff_dv == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign jam_entry = (state_d == ST_JAM) && (state_q != ST_JAM);

  // Collision counting, partitioning and reconnection per port.
  always_comb begin
    ccnt_d        = ccnt_q;
    rcnt_d        = rcnt_q;
    partitioned_d = partitioned_q;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (jam_entry && eff_dv[i]) begin
        if (ccnt_q[i] != CCNT_W'(PARTITION_LIMIT)) ccnt_d[i] = ccnt_q[i] + CCNT_W'(1);
        if (ccnt_d[i] == CCNT_W'(PARTITION_LIMIT)) partitioned_d[i] = 1'b1;
      end
      if (clean_eof && IDX_W'(i) == active_q) ccnt_d[i] = '0;
      if (!rx_dv[i]) begin
        if (partitioned_q[i] && rcnt_q[i] == RCNT_W'(RECONNECT_LIMIT)) begin
          partitioned_d[i] = 1'b0;
          ccnt_d[i]        = '0;
        end
        rcnt_d[i] = '0;
      end else if (partitioned_q[i] && rcnt_q[i] != RCNT_W'(RECONNECT_LIMIT)) begin
        rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
      end
    end
  end

  // Outputs follow the state being entered and the nibble sampled now.
  always_comb begin
    tx_en_d     = '0;
    tx_er_d     = '0;
    txd_d       = '0;
    collision_d = 1'b0;
    jabber_d    = 1'b0;
    fwd_rxd     = '0;
    fwd_er      = 1'b0;
    for (int unsigned i = 0; i < PORT_COUNT; i++) begin
      if (IDX_W'(i) == active_d) begin
        fwd_rxd = rxd[4*i +: 4];
        fwd_er  = rx_er[i];
      end
    end
    case (state_d)
      ST_REPEAT: begin
        for (int unsigned i = 0; i < PORT_COUNT; i++) begin
          if (IDX_W'(i) != active_d) begin
            tx_en_d[i]       = 1'b1;
            tx_er_d[i]       = fwd_er;
            txd_d[4*i +: 4]  = fwd_rxd;
          end
        end
      end
      ST_JAM: begin
        tx_en_d     = '1;
        txd_d       = {PORT_COUNT{4'h5}};
        collision_d = 1'b1;
      end
      ST_JABBER: jabber_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      active_q      <= '0;
      ccnt_q        <= '0;
      rcnt_q        <= '0;
      partitioned_q <= '0;
      tx_en_q       <= '0;
      tx_er_q       <= '0;
      txd_q         <= '0;
      collision_q   <= 1'b0;
      jabber_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      ccnt_q        <= ccnt_d;
      rcnt_q        <= rcnt_d;
      partitioned_q <= partitioned_d;
      tx_en_q       <= tx_en_d;
      tx_er_q       <= tx_er_d;
      txd_q         <= txd_d;
      collision_q   <= collision_d;
      jabber_q      <= jabber_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_er       = tx_er_q;
  assign txd         = txd_q;
  assign collision   = collision_q;
  assign jabber      = jabber_q;
  assign partitioned = partitioned_q;

endmodule

// File: tb/tb_hub_repeater.sv
// Bench for hub_repeater: directed scenarios plus random traffic, every cycle
// checked against a frame-level reference model of the hub.
module tb_hub_repeater;

  localparam int unsigned P  = 4;
  localparam int unsigned JM = 24;
  localparam int unsigned JL = 5000;
  localparam int unsigned PL = 31;
  localparam int unsigned RL = 128;

  localparam int M_IDLE = 0;
  localparam int M_REP  = 1;
  localparam int M_JAM  = 2;
  localparam int M_JAB  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [P-1:0]  rx_dv, rx_er;
  logic [4*P-1:0] rxd;
  logic [P-1:0]  tx_en, tx_er, partitioned;
  logic [4*P-1:0] txd;
  logic          collision, jabber;

  hub_repeater #(
    .PORT_COUNT(P), .JAM_MIN(JM), .JABBER_LIMIT(JL),
    .PARTITION_LIMIT(PL), .RECONNECT_LIMIT(RL)
  ) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .tx_en(tx_en), .tx_er(tx_er), .txd(txd),
    .collision(collision), .jabber(jabber), .partitioned(partitioned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state, kept in spec terms
  int       m_mode, m_act, m_len;
  int       m_coll[P];
  int       m_rc[P];
  bit [P-1:0]   m_part;
  bit [P-1:0]   e_en, e_er;
  bit [4*P-1:0] e_txd;
  bit           e_col, e_jab;

  // Directed observation counters
  int en_cnt[P];
  int col_cnt, jab_cnt, txd_sum0;

  task automatic model_step();
    bit [P-1:0] eff;
    int n, first, nxt;
    if (rst) begin
      m_mode = M_IDLE; m_act = 0; m_len = 0; m_part = '0;
      for (int i = 0; i < P; i++) begin m_coll[i] = 0; m_rc[i] = 0; end
      e_en = '0; e_er = '0; e_txd = '0; e_col = 0; e_jab = 0;
      return;
    end
    eff = rx_dv & ~m_part;
    n = $countones(eff);
    first = -1;
    for (int i = 0; i < P; i++) if (eff[i] && first < 0) first = i;
    nxt = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (n == 1) begin nxt = M_REP; m_act = first; m_len = 1; end
        else if (n >= 2) begin nxt = M_JAM; m_len = 1; end
      end
      M_REP: begin
        if (n >= 2) begin nxt = M_JAM; m_len = 1; end
        else if (!rx_dv[m_act]) begin nxt = M_IDLE; m_coll[m_act] = 0; end
        else if (m_len == JL) nxt = M_JAB;
        else m_len++;
      end
      M_JAM: begin
        if (m_len >= JM && n == 0) nxt = M_IDLE;
        else if (m_len == JL) nxt = M_JAB;
        else m_len++;
      end
      default: if (eff == 0) nxt = M_IDLE;
    endcase
    for (int i = 0; i < P; i++) begin
      if (!rx_dv[i]) begin
        if (m_part[i] && m_rc[i] == RL) begin m_part[i] = 0; m_coll[i] = 0; end
        m_rc[i] = 0;
      end else if (m_part[i]) begin
        m_rc[i] = (m_rc[i] < RL) ? m_rc[i] + 1 : RL;
      end
    end
    if (nxt == M_JAM && m_mode != M_JAM) begin
      for (int i = 0; i < P; i++) if (eff[i]) begin
        if (m_coll[i] < PL) m_coll[i]++;
        if (m_coll[i] == PL) m_part[i] = 1;
      end
    end
    m_mode = nxt;
    e_en = '0; e_er = '0; e_txd = '0; e_col = 0; e_jab = 0;
    if (m_mode == M_REP) begin
      for (int i = 0; i < P; i++) if (i != m_act) begin
        e_en[i] = 1; e_er[i] = rx_er[m_act]; e_txd[4*i +: 4] = rxd[4*m_act +: 4];
      end
    end else if (m_mode == M_JAM) begin
      e_en = '1; e_txd = {P{4'h5}}; e_col = 1;
    end else if (m_mode == M_JAB) begin
      e_jab = 1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_eq("cycle_outputs", {tx_en, tx_er, txd, collision, jabber, partitioned},
             {e_en, e_er, e_txd, e_col, e_jab, m_part});
    for (int i = 0; i < P; i++) en_cnt[i] += int'(tx_en[i]);
    col_cnt += int'(collision);
    jab_cnt += int'(jabber);
    if (tx_en[0]) txd_sum0 += int'(txd[3:0]);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < P; i++) en_cnt[i] = 0;
    col_cnt = 0; jab_cnt = 0; txd_sum0 = 0;
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rx_dv = '0; rx_er = '0; rxd = 16'($urandom);
      step();
    end
  endtask

  task automatic frame(input int port, input int len);
    for (int k = 0; k < len; k++) begin
      rx_dv = P'(1 << port); rx_er = '0; rxd = 16'($urandom);
      rxd[4*port +: 4] = 4'(k);
      step();
    end
    rx_dv = '0;
  endtask

  task automatic collide(input int a, input int b, input int len);
    for (int k = 0; k < len; k++) begin
      rx_dv = P'((1 << a) | (1 << b)); rx_er = 4'($urandom); rxd = 16'($urandom);
      step();
    end
    rx_dv = '0;
  endtask

  task automatic partition_pair(input int a, input int b);
    for (int k = 0; k < PL; k++) begin
      collide(a, b, 3);
      idle(26);
    end
  endtask

  int rem[P];

  initial begin
    rst = 1'b1; rx_dv = '0; rx_er = '0; rxd = '0;
    clear_counts();
    for (int k = 0; k < 3; k++) step();
    check_eq("reset_tx_en", tx_en, 0);
    check_eq("reset_flags", {collision, jabber, partitioned}, 0);
    rst = 1'b0;
    idle(3);

    // Single clean frame from port 1
    clear_counts();
    frame(1, 10);
    idle(3);
    check_eq("frame_p0_len", en_cnt[0], 10);
    check_eq("frame_p2_len", en_cnt[2], 10);
    check_eq("frame_p3_len", en_cnt[3], 10);
    check_eq("frame_src_silent", en_cnt[1], 0);
    check_eq("frame_no_col", col_cnt, 0);
    check_eq("frame_txd_sum", txd_sum0, 45);

    // Short collision gives a minimum-length jam
    clear_counts();
    collide(0, 2, 3);
    idle(30);
    check_eq("jam_len_p1", en_cnt[1], JM);
    check_eq("jam_col_len", col_cnt, JM);

    // Clear port 2's collision count, then partition ports 2 and 3
    frame(2, 5);
    idle(3);
    for (int k = 0; k < PL - 1; k++) begin collide(2, 3, 3); idle(26); end
    check_eq("part_before_limit", partitioned, 4'b0000);
    collide(2, 3, 3);
    idle(26);
    check_eq("part_at_limit", partitioned, 4'b1100);

    clear_counts();
    frame(2, 10);
    idle(3);
    check_eq("part_blocked", en_cnt[0] + en_cnt[1], 0);
    clear_counts();
    frame(0, 8);
    idle(3);
    check_eq("part_still_rx", en_cnt[2], 8);

    // Reset in the middle of a jam
    for (int k = 0; k < 5; k++) begin rx_dv = 4'b0011; rxd = 16'($urandom); step(); end
    check_eq("jam_before_rst", collision, 1);
    rst = 1'b1; rx_dv = '0;
    step();
    check_eq("rst_mid_jam_out", {tx_en, tx_er, txd, collision, jabber}, 0);
    check_eq("rst_mid_jam_part", partitioned, 0);
    rst = 1'b0;
    idle(5);

    // Jabber cut-off on a 6000-cycle stream
    clear_counts();
    for (int k = 0; k < 6000; k++) begin
      rx_dv = 4'b1000; rx_er = 4'($urandom); rxd = 16'($urandom);
      step();
    end
    idle(3);
    check_eq("jabber_rep_len", en_cnt[0], JL);
    check_eq("jabber_src_silent", en_cnt[3], 0);
    check_eq("jabber_len", jab_cnt, 6000 - JL);

    // Reconnection: one cycle short stays partitioned, full length reconnects
    partition_pair(1, 2);
    check_eq("repart", partitioned, 4'b0110);
    for (int k = 0; k < RL - 1; k++) begin rx_dv = 4'b0010; rxd = 16'($urandom); step(); end
    rx_dv = '0; step();
    check_eq("reconn_short", partitioned, 4'b0110);
    for (int k = 0; k < RL; k++) begin rx_dv = 4'b0100; rxd = 16'($urandom); step(); end
    rx_dv = '0; step();
    check_eq("reconn_full", partitioned, 4'b0010);
    clear_counts();
    frame(2, 6);
    idle(3);
    check_eq("reconn_rep_p0", en_cnt[0], 6);
    check_eq("reconn_rep_p1", en_cnt[1], 6);

    // Random traffic
    for (int i = 0; i < P; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < P; i++) begin
        if (rem[i] > 0) rem[i]--;
        else if ($urandom_range(99) < 3)
          rem[i] = ($urandom_range(9) == 0) ? int'($urandom_range(200, 100)) : int'($urandom_range(40, 1));
        rx_dv[i] = (rem[i] > 0);
      end
      rx_er = 4'($urandom);
      rxd   = 16'($urandom);
      rst   = ($urandom_range(799) == 0);
      step();
    end
    rst = 1'b0;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
